// File: rtl/fetch_queue.sv
// Show-ahead instruction queue between fetch and decode.
// Holds {pc, instr} pairs; flush drops everything in one cycle.
module fetch_queue #(
  parameter int bits  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [bits-1:0]            in_instr,
  input  logic [bits-1:0]            in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [bits-1:0]            out_instr,
  output logic [bits-1:0]            out_pc,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULLV = CW'(DEPTH);

  logic [bits-1:0] r_instr [DEPTH];
  logic [bits-1:0] r_pc    [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;

  assign w_full  = (r_cnt == FULLV);
  assign w_empty = (r_cnt == '0);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_instr = r_instr[r_rd];
  assign out_pc    = r_pc[r_rd];
  assign count     = r_cnt;
  assign full      = w_full;
  assign empty     = w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push) begin
      r_instr[r_wr] <= in_instr;
      r_pc[r_wr]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model.
// Outputs are sampled on the falling edge.
module tb_fetch_queue;

  localparam int B = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [B-1:0] in_instr = '0;
  logic [B-1:0] in_pc = '0;
  logic         in_ready;
  logic         out_valid;
  logic [B-1:0] out_instr;
  logic [B-1:0] out_pc;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   count;
  logic         full;
  logic         empty;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.bits(B), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_ready(out_ready),
    .flush(flush), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference: a plain queue of {pc, instr}
  logic [63:0] mq[$];
  bit          known = 0;

  always @(posedge clk) begin
    int sz;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      known = 1;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (out_ready && sz > 0) void'(mq.pop_front());
      if (in_valid && sz < D) mq.push_back({in_pc, in_instr});
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (known) begin
      int sz;
      sz = mq.size();
      chk("m_count", 32'(count), 32'(sz));
      chk("m_full", 32'(full), 32'(sz == D));
      chk("m_empty", 32'(empty), 32'(sz == 0));
      chk("m_ovalid", 32'(out_valid), 32'(sz != 0));
      chk("m_iready", 32'(in_ready), 32'(sz != D));
      if (sz != 0) begin
        chk("m_opc", out_pc, mq[0][63:32]);
        chk("m_oinstr", out_instr, mq[0][31:0]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic [31:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] tbl [4];

  initial begin
    tbl[0] = 32'hCAFECAFE;
    tbl[1] = 32'hFAFAFAFA;
    tbl[2] = 32'hBEEFBEEF;
    tbl[3] = 32'h000000A1;
    step();

    // 1: reset then fill
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ovalid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) push(32'(4 * i), tbl[i]);
    chk("fill_count", 32'(count), 4);
    chk("fill_full", 32'(full), 1);
    chk("fill_iready", 32'(in_ready), 0);
    chk("fill_pc", out_pc, 32'h0);
    chk("fill_instr", out_instr, 32'hCAFECAFE);
    step();
    chk("hold_pc", out_pc, 32'h0);
    chk("hold_instr", out_instr, 32'hCAFECAFE);

    // 2: drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_instr", out_instr, tbl[i]);
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovalid", 32'(out_valid), 0);

    // 3: streaming across wrap
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc    = 32'h100 + 32'(4 * i);
      in_instr = 32'(i);
      step();
      chk("strm_count", 32'(count), 1);
      chk("strm_pc", out_pc, 32'h100 + 32'(4 * i));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("strm_empty", 32'(empty), 1);

    // 4: full with simultaneous pop
    for (int i = 0; i < 4; i++)
      push(32'h300 + 32'(4 * i), 32'(i));
    in_valid  = 1'b1;
    in_pc     = 32'h400;
    in_instr  = 32'hDEADBEEF;
    out_ready = 1'b1;
    chk("fp_iready", 32'(in_ready), 0);
    step();
    chk("fp_count", 32'(count), 3);
    chk("fp_head", out_pc, 32'h304);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("fp_count2", 32'(count), 4);
    out_ready = 1'b1;
    chk("fp_o1", out_pc, 32'h304);
    step();
    chk("fp_o2", out_pc, 32'h308);
    step();
    chk("fp_o3", out_pc, 32'h30C);
    step();
    chk("fp_o4", out_pc, 32'h400);
    chk("fp_o4i", out_instr, 32'hDEADBEEF);
    step();
    out_ready = 1'b0;
    chk("fp_empty", 32'(empty), 1);

    // 5: flush with push and pop
    push(32'h500, 32'h1);
    push(32'h504, 32'h2);
    chk("fl_count", 32'(count), 2);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h508;
    out_ready = 1'b1;
    chk("fl_iready", 32'(in_ready), 1);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fl_count0", 32'(count), 0);
    chk("fl_ovalid", 32'(out_valid), 0);
    push(32'h200, 32'h7);
    chk("fl_head", out_pc, 32'h200);
    chk("fl_count1", 32'(count), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 6: reset mid-stream
    for (int i = 0; i < 3; i++)
      push(32'h600 + 32'(4 * i), 32'(i));
    chk("mr_count", 32'(count), 3);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h700;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mr_count0", 32'(count), 0);
    chk("mr_empty", 32'(empty), 1);
    chk("mr_ovalid", 32'(out_valid), 0);
    step();
    chk("mr_discard", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
